alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU port interface: accepts one operation request per handshake and drives ALUOp, inA, inB, shiftcarry_in and reg_file_ctr into the combinational ALU.
- Holds those operands stable for a programmable settle window, then captures rslt, shiftcarry_out, branchFlag and alu_ctr.
- Presents the captured values on a registered response channel.
- Owns the architectural carry flag that is fed back as shiftcarry_in. Sits between the decode/issue stage and the ALU.

Parameters:
SETTLE, 1, number of clock edges ALU inputs are held before results are sampled (1..15)
CTR_W, 12, width of the register-file control tag passed through the ALU

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  4  ALU opcode
req_a  in  8  operand A
req_b  in  8  operand B
req_ctr  in  CTR_W  register-file control tag
clr_carry  in  1  synchronous clear of carry flag
ALUOp  out  4  to ALU
inA  out  8  to ALU
inB  out  8  to ALU
shiftcarry_in  out  1  to ALU, equals carry flag
reg_file_ctr  out  CTR_W  to ALU
rslt  in  8  from ALU
shiftcarry_out  in  1  from ALU
branchFlag  in  1  from ALU
alu_ctr  in  CTR_W  from ALU
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rslt  out  8  captured result
rsp_branch  out  1  captured branchFlag
rsp_carry  out  1  captured shiftcarry_out
rsp_ctr  out  CTR_W  captured alu_ctr
tag_err  out  1  sticky: alu_ctr differed from reg_file_ctr at capture

Behaviour:
- Reset: the block is in IDLE. req_ready=1 and rsp_valid=0. ALUOp, inA, inB, reg_file_ctr, all rsp_* outputs, the carry flag (so shiftcarry_in) and tag_err are 0. Reset takes effect immediately, mid-operation included; any in-flight request or pending response is discarded.
- FSM states:
  - IDLE:
    - req_ready=1.
    - On an edge with req_valid=1: register req_op, req_a, req_b and req_ctr onto the ALU ports, load cnt=SETTLE-1, go to DRIVE.
  - DRIVE:
    - req_ready=0. ALU inputs are held constant.
    - Each edge with cnt!=0 decrements cnt.
    - On the edge with cnt==0, capture rslt into rsp_rslt, branchFlag into rsp_branch, shiftcarry_out into rsp_carry and alu_ctr into rsp_ctr.
    - On that same edge, the carry flag is loaded with shiftcarry_out, and tag_err is set if alu_ctr!=reg_file_ctr. Then go to RESP.
  - RESP:
    - rsp_valid=1, req_ready=0. rsp_* outputs are stable until the handshake.
    - On an edge with rsp_ready=1, go to IDLE.
- Latency: rsp_valid rises exactly SETTLE edges after the accept edge. Minimum issue interval is SETTLE+2 edges.
- ALU input ports keep their last values in IDLE and RESP; they change only on an accept edge.
- shiftcarry_in is always the current carry flag. Within DRIVE it is therefore the carry produced by the previous completed op.
- clr_carry:
  - Clears the carry flag on any edge.
  - If it coincides with the DRIVE capture edge, the clear wins and the flag is 0.
  - It does not affect rsp_carry.
- tag_err is sticky until reset.
- Requests arriving while req_ready=0 are ignored; the requester must hold req_valid.
- SETTLE outside 1..15 is illegal.

Test Plan:
- Reset, then issue op=0000, A=0xAA, B=0xCC with SETTLE=1 and a model ALU → rsp_valid rises 1 edge after accept; rsp_rslt=0x88; ALUOp/inA/inB stay held through RESP.
- op=0101, A=0x01, B=0x01 → rsp_rslt=0x02. Then op=0110, A=0x02, B=0x01 → rsp_rslt=0x01. Hold rsp_ready=0 for 3 cycles → rsp_* are stable and req_ready stays 0 until rsp_ready=1.
- op=1001, A=B=0x02 → rsp_branch=1. Then A=0x02, B=0x03 → rsp_branch=0.
- Carry chaining:
  - First op's model returns shiftcarry_out=1 → shiftcarry_in=1 while the next op is in DRIVE.
  - op=1010, A=0x02, B=0x01 with carry 1 → rsp_rslt=0x02.
  - Assert clr_carry on a capture edge → shiftcarry_in=0 afterward, while rsp_carry=1.
- SETTLE=4; the model ALU corrupts alu_ctr (0x001 sent, 0x002 returned) → rsp_valid exactly 4 edges after accept, rsp_ctr=0x002, tag_err=1 and it persists across later ops.
- Assert rst_n low during DRIVE and again during RESP → outputs return to reset values asynchronously; the next request completes normally.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Port bundle between the issue stage, alu_issue_ctrl and the combinational ALU.
// slave is the controller's view; master is the environment (issue, ALU, consumer).
interface alu_issue_ctrl_if #(
   parameter int unsigned CTR_W = 12
) ();
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [7:0]       req_a;
   logic [7:0]       req_b;
   logic [CTR_W-1:0] req_ctr;
   logic             clr_carry;

   logic [3:0]       ALUOp;
   logic [7:0]       inA;
   logic [7:0]       inB;
   logic             shiftcarry_in;
   logic [CTR_W-1:0] reg_file_ctr;
   logic [7:0]       rslt;
   logic             shiftcarry_out;
   logic             branchFlag;
   logic [CTR_W-1:0] alu_ctr;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [7:0]       rsp_rslt;
   logic             rsp_branch;
   logic             rsp_carry;
   logic [CTR_W-1:0] rsp_ctr;
   logic             tag_err;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_ctr, clr_carry,
      input  rslt, shiftcarry_out, branchFlag, alu_ctr, rsp_ready,
      output req_ready, ALUOp, inA, inB, shiftcarry_in, reg_file_ctr,
      output rsp_valid, rsp_rslt, rsp_branch, rsp_carry, rsp_ctr, tag_err
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_ctr, clr_carry,
      output rslt, shiftcarry_out, branchFlag, alu_ctr, rsp_ready,
      input  req_ready, ALUOp, inA, inB, shiftcarry_in, reg_file_ctr,
      input  rsp_valid, rsp_rslt, rsp_branch, rsp_carry, rsp_ctr, tag_err
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: latches one request onto the ALU
// ports, waits SETTLE edges, captures the results and holds them as a response.
module alu_issue_ctrl #(
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CTR_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_ctrl_if.slave   bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;
   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   function automatic logic tag_mismatch(input logic [CTR_W-1:0] sent,
                                         input logic [CTR_W-1:0] back);
      return (sent != back);
   endfunction

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [3:0]       cnt_r;
   logic             accept_s;
   logic             capture_s;
   logic             req_ready_r;
   logic             rsp_valid_r;

   logic [3:0]       alu_op_r;
   logic [7:0]       in_a_r;
   logic [7:0]       in_b_r;
   logic [CTR_W-1:0] ctr_r;
   logic             carry_r;

   logic [7:0]       rsp_rslt_r;
   logic             rsp_branch_r;
   logic             rsp_carry_r;
   logic [CTR_W-1:0] rsp_ctr_r;
   logic             tag_err_r;

   // Next-state decode plus the accept and capture strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      capture_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.req_valid) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_DRIVE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (cnt_r == 4'd0) begin
               capture_s   = 1'b1;
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_DRIVE;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register; handshake flags are derived from the next state so they are flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         req_ready_r <= (state_nxt_s == ST_IDLE);
         rsp_valid_r <= (state_nxt_s == ST_RESP);
      end
   end

   // Settle counter: loaded on accept, counts down while the ALU inputs are held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 4'd0;
      end else if (accept_s) begin
         cnt_r <= CNT_INIT;
      end else if ((state_r == ST_DRIVE) && (cnt_r != 4'd0)) begin
         cnt_r <= cnt_r - 4'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // ALU operand registers change only on an accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op_r <= 4'd0;
         in_a_r   <= 8'd0;
         in_b_r   <= 8'd0;
         ctr_r    <= '0;
      end else if (accept_s) begin
         alu_op_r <= bus.req_op;
         in_a_r   <= bus.req_a;
         in_b_r   <= bus.req_b;
         ctr_r    <= bus.req_ctr;
      end else begin
         alu_op_r <= alu_op_r;
         in_a_r   <= in_a_r;
         in_b_r   <= in_b_r;
         ctr_r    <= ctr_r;
      end
   end

   // Response capture at the end of the settle window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rslt_r   <= 8'd0;
         rsp_branch_r <= 1'b0;
         rsp_carry_r  <= 1'b0;
         rsp_ctr_r    <= '0;
      end else if (capture_s) begin
         rsp_rslt_r   <= bus.rslt;
         rsp_branch_r <= bus.branchFlag;
         rsp_carry_r  <= bus.shiftcarry_out;
         rsp_ctr_r    <= bus.alu_ctr;
      end else begin
         rsp_rslt_r   <= rsp_rslt_r;
         rsp_branch_r <= rsp_branch_r;
         rsp_carry_r  <= rsp_carry_r;
         rsp_ctr_r    <= rsp_ctr_r;
      end
   end

   // Architectural carry flag; a clear on the capture edge beats the new carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_r <= 1'b0;
      end else if (bus.clr_carry) begin
         carry_r <= 1'b0;
      end else if (capture_s) begin
         carry_r <= bus.shiftcarry_out;
      end else begin
         carry_r <= carry_r;
      end
   end

   // Sticky tag error: the tag returned by the ALU must match the one sent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_err_r <= 1'b0;
      end else if (capture_s && tag_mismatch(ctr_r, bus.alu_ctr)) begin
         tag_err_r <= 1'b1;
      end else begin
         tag_err_r <= tag_err_r;
      end
   end

   assign bus.req_ready     = req_ready_r;
   assign bus.rsp_valid     = rsp_valid_r;
   assign bus.ALUOp         = alu_op_r;
   assign bus.inA           = in_a_r;
   assign bus.inB           = in_b_r;
   assign bus.reg_file_ctr  = ctr_r;
   assign bus.shiftcarry_in = carry_r;
   assign bus.rsp_rslt      = rsp_rslt_r;
   assign bus.rsp_branch    = rsp_branch_r;
   assign bus.rsp_carry     = rsp_carry_r;
   assign bus.rsp_ctr       = rsp_ctr_r;
   assign bus.tag_err       = tag_err_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (SETTLE=1 and SETTLE=4) share one stimulus
// path selected by sel; a behavioural ALU model sits on each ALU port.
module tb_alu_issue_ctrl;

   typedef struct {
      logic        sel;
      logic [3:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [11:0] ctr;
      logic        corrupt;
      logic        clr;
      int          hold;
      logic        cin;
      logic [7:0]  rslt;
      logic        br;
      logic        cout;
      logic [11:0] rctr;
      logic        tag;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic        req_valid;
   logic        rsp_ready;
   logic        clr_carry;
   logic        corrupt_b;
   logic [3:0]  req_op;
   logic [7:0]  req_a;
   logic [7:0]  req_b;
   logic [11:0] req_ctr;

   int n_chk  = 0;
   int n_pass = 0;
   vec_t vt [17];
   vec_t exp_q [$];

   always #5 clk = ~clk;

   alu_issue_ctrl_if #(.CTR_W(12)) ifa ();
   alu_issue_ctrl_if #(.CTR_W(12)) ifb ();

   alu_issue_ctrl #(.SETTLE(1), .CTR_W(12)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   alu_issue_ctrl #(.SETTLE(4), .CTR_W(12)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   // Behavioural ALU: returns {branch, carry_out, result}.
   function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
      logic [8:0] t;
      logic [9:0] r;
      r = 10'd0;
      t = 9'd0;
      case (op)
         4'b0000: r = {2'b00, a & b};
         4'b0101: begin t = {1'b0, a} + {1'b0, b}; r = {1'b0, t[8], t[7:0]}; end
         4'b0110: r = {1'b0, (a < b), a - b};
         4'b0111: r = {1'b0, a[7], a[6:0], cin};
         4'b1001: r = {(a == b), 1'b0, 8'h00};
         4'b1010: r = {2'b00, a - b + {7'd0, cin}};
         default: r = {2'b00, a | b};
      endcase
      return r;
   endfunction

   assign {ifa.branchFlag, ifa.shiftcarry_out, ifa.rslt} =
      alu_f(ifa.ALUOp, ifa.inA, ifa.inB, ifa.shiftcarry_in);
   assign {ifb.branchFlag, ifb.shiftcarry_out, ifb.rslt} =
      alu_f(ifb.ALUOp, ifb.inA, ifb.inB, ifb.shiftcarry_in);
   assign ifa.alu_ctr = ifa.reg_file_ctr;
   assign ifb.alu_ctr = corrupt_b ? ifb.reg_file_ctr + 12'd1 : ifb.reg_file_ctr;

   assign ifa.req_valid = req_valid & ~sel;
   assign ifb.req_valid = req_valid & sel;
   assign ifa.rsp_ready = rsp_ready & ~sel;
   assign ifb.rsp_ready = rsp_ready & sel;
   assign ifa.clr_carry = clr_carry;
   assign ifb.clr_carry = clr_carry;
   assign ifa.req_op  = req_op;
   assign ifb.req_op  = req_op;
   assign ifa.req_a   = req_a;
   assign ifb.req_a   = req_a;
   assign ifa.req_b   = req_b;
   assign ifb.req_b   = req_b;
   assign ifa.req_ctr = req_ctr;
   assign ifb.req_ctr = req_ctr;

   logic        m_req_ready, m_rsp_valid, m_cin, m_branch, m_carry, m_tag_err;
   logic [3:0]  m_op;
   logic [7:0]  m_in_a, m_in_b, m_rslt;
   logic [11:0] m_rfc, m_rctr;
   assign m_req_ready = sel ? ifb.req_ready     : ifa.req_ready;
   assign m_rsp_valid = sel ? ifb.rsp_valid     : ifa.rsp_valid;
   assign m_cin       = sel ? ifb.shiftcarry_in : ifa.shiftcarry_in;
   assign m_branch    = sel ? ifb.rsp_branch    : ifa.rsp_branch;
   assign m_carry     = sel ? ifb.rsp_carry     : ifa.rsp_carry;
   assign m_tag_err   = sel ? ifb.tag_err       : ifa.tag_err;
   assign m_op        = sel ? ifb.ALUOp         : ifa.ALUOp;
   assign m_in_a      = sel ? ifb.inA           : ifa.inA;
   assign m_in_b      = sel ? ifb.inB           : ifa.inB;
   assign m_rslt      = sel ? ifb.rsp_rslt      : ifa.rsp_rslt;
   assign m_rfc       = sel ? ifb.reg_file_ctr  : ifa.reg_file_ctr;
   assign m_rctr      = sel ? ifb.rsp_ctr       : ifa.rsp_ctr;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: actual=%0h required=%0h", nm, idx, act, exp);
   endtask

   task automatic chk_rst(input int idx);
      chk("rst_req_ready", idx, 32'(m_req_ready), 32'd1);
      chk("rst_rsp_valid", idx, 32'(m_rsp_valid), 32'd0);
      chk("rst_aluop",     idx, 32'(m_op),        32'd0);
      chk("rst_ina",       idx, 32'(m_in_a),      32'd0);
      chk("rst_inb",       idx, 32'(m_in_b),      32'd0);
      chk("rst_rfc",       idx, 32'(m_rfc),       32'd0);
      chk("rst_cin",       idx, 32'(m_cin),       32'd0);
      chk("rst_rslt",      idx, 32'(m_rslt),      32'd0);
      chk("rst_branch",    idx, 32'(m_branch),    32'd0);
      chk("rst_carry",     idx, 32'(m_carry),     32'd0);
      chk("rst_rctr",      idx, 32'(m_rctr),      32'd0);
      chk("rst_tag_err",   idx, 32'(m_tag_err),   32'd0);
   endtask

   task automatic do_op(input int idx, input vec_t v);
      int   lat;
      logic got;
      int   settle;
      vec_t e;
      settle = v.sel ? 4 : 1;
      @(negedge clk);
      sel = v.sel;
      corrupt_b = v.corrupt;
      req_op = v.op; req_a = v.a; req_b = v.b; req_ctr = v.ctr;
      req_valid = 1'b1;
      exp_q.push_back(v);
      #1 chk("req_ready_idle", idx, 32'(m_req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("req_ready_busy", idx, 32'(m_req_ready), 32'd0);
      chk("cin_drive",      idx, 32'(m_cin),       32'(v.cin));
      chk("ina_drive",      idx, 32'(m_in_a),      32'(v.a));
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (lat == settle - 1) clr_carry = v.clr;
         @(posedge clk);
         lat++;
         @(negedge clk);
         clr_carry = 1'b0;
         if (m_rsp_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk("rsp_seen", idx, 32'(got), 32'd1);
      chk("latency",  idx, 32'(lat), 32'(settle));
      e = exp_q.pop_front();
      chk("rsp_rslt",   idx, 32'(m_rslt),    32'(e.rslt));
      chk("rsp_branch", idx, 32'(m_branch),  32'(e.br));
      chk("rsp_carry",  idx, 32'(m_carry),   32'(e.cout));
      chk("rsp_ctr",    idx, 32'(m_rctr),    32'(e.rctr));
      chk("tag_err",    idx, 32'(m_tag_err), 32'(e.tag));
      chk("aluop_held", idx, 32'(m_op),      32'(e.op));
      chk("inb_held",   idx, 32'(m_in_b),    32'(e.b));
      chk("rfc_held",   idx, 32'(m_rfc),     32'(e.ctr));
      chk("cin_after",  idx, 32'(m_cin),     32'(e.clr ? 1'b0 : e.cout));
      for (int h = 0; h < v.hold; h++) begin
         req_valid = 1'b1;
         req_a = ~v.a;
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", idx, 32'(m_rsp_valid), 32'd1);
         chk("hold_ready", idx, 32'(m_req_ready), 32'd0);
         chk("hold_rslt",  idx, 32'(m_rslt),      32'(e.rslt));
         chk("hold_ina",   idx, 32'(m_in_a),      32'(e.a));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rel_valid", idx, 32'(m_rsp_valid), 32'd0);
      chk("rel_ready", idx, 32'(m_req_ready), 32'd1);
   endtask

   initial begin
      //        sel   op     a      b      ctr      cor   clr  hold cin   rslt   br    cout  rctr     tag
      vt[0]  = '{1'b0, 4'h0, 8'hAA, 8'hCC, 12'h011, 1'b0, 1'b0, 0, 1'b0, 8'h88, 1'b0, 1'b0, 12'h011, 1'b0};
      vt[1]  = '{1'b0, 4'h5, 8'h01, 8'h01, 12'h012, 1'b0, 1'b0, 0, 1'b0, 8'h02, 1'b0, 1'b0, 12'h012, 1'b0};
      vt[2]  = '{1'b0, 4'h6, 8'h02, 8'h01, 12'h013, 1'b0, 1'b0, 3, 1'b0, 8'h01, 1'b0, 1'b0, 12'h013, 1'b0};
      vt[3]  = '{1'b0, 4'h9, 8'h02, 8'h02, 12'h014, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 12'h014, 1'b0};
      vt[4]  = '{1'b0, 4'h9, 8'h02, 8'h03, 12'h015, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h015, 1'b0};
      vt[5]  = '{1'b0, 4'h7, 8'h80, 8'h00, 12'h016, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 12'h016, 1'b0};
      vt[6]  = '{1'b0, 4'hA, 8'h02, 8'h01, 12'h017, 1'b0, 1'b0, 0, 1'b1, 8'h02, 1'b0, 1'b0, 12'h017, 1'b0};
      vt[7]  = '{1'b0, 4'h7, 8'hC1, 8'h00, 12'h018, 1'b0, 1'b0, 0, 1'b0, 8'h82, 1'b0, 1'b1, 12'h018, 1'b0};
      vt[8]  = '{1'b0, 4'h7, 8'h81, 8'h00, 12'h019, 1'b0, 1'b1, 0, 1'b1, 8'h03, 1'b0, 1'b1, 12'h019, 1'b0};
      vt[9]  = '{1'b0, 4'h5, 8'h10, 8'h20, 12'h01A, 1'b0, 1'b0, 0, 1'b0, 8'h30, 1'b0, 1'b0, 12'h01A, 1'b0};
      vt[10] = '{1'b0, 4'h5, 8'hFF, 8'h01, 12'h01B, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 12'h01B, 1'b0};
      vt[11] = '{1'b0, 4'h6, 8'h05, 8'h07, 12'h01C, 1'b0, 1'b0, 0, 1'b1, 8'hFE, 1'b0, 1'b1, 12'h01C, 1'b0};
      vt[12] = '{1'b0, 4'hF, 8'h0F, 8'hF0, 12'h01D, 1'b0, 1'b0, 0, 1'b1, 8'hFF, 1'b0, 1'b0, 12'h01D, 1'b0};
      vt[13] = '{1'b1, 4'h5, 8'h03, 8'h04, 12'h001, 1'b1, 1'b0, 0, 1'b0, 8'h07, 1'b0, 1'b0, 12'h002, 1'b1};
      vt[14] = '{1'b1, 4'h0, 8'hF0, 8'h3C, 12'h005, 1'b0, 1'b0, 2, 1'b0, 8'h30, 1'b0, 1'b0, 12'h005, 1'b1};
      vt[15] = '{1'b0, 4'h5, 8'h22, 8'h11, 12'h020, 1'b0, 1'b0, 0, 1'b0, 8'h33, 1'b0, 1'b0, 12'h020, 1'b0};
      vt[16] = '{1'b1, 4'h9, 8'h7E, 8'h7E, 12'h0FF, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 12'h0FF, 1'b0};

      rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; clr_carry = 1'b0;
      corrupt_b = 1'b0; req_op = 4'd0; req_a = 8'd0; req_b = 8'd0; req_ctr = 12'd0;
      repeat (2) @(negedge clk);
      chk_rst(0);
      sel = 1'b1;
      #1 chk_rst(1);
      @(negedge clk);
      rst_n = 1'b1;
      sel = 1'b0;

      for (int i = 0; i < 15; i++) do_op(i, vt[i]);

      // Reset while the SETTLE=4 instance is mid-DRIVE (tag_err is set beforehand).
      @(negedge clk);
      sel = 1'b1;
      req_op = 4'h5; req_a = 8'h11; req_b = 8'h22; req_ctr = 12'h033;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("pre_rst_tag", 2, 32'(m_tag_err), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_rst(2);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while the SETTLE=1 instance holds a response.
      sel = 1'b0;
      @(negedge clk);
      req_op = 4'h0; req_a = 8'hFF; req_b = 8'h0F; req_ctr = 12'h044;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_resp", 3, 32'(m_rsp_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_rst(3);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 15; i < 17; i++) do_op(i, vt[i]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
